// File: rtl/ahb_rr_switch_if.sv
// rtl/ahb_rr_switch_if.sv - master-side requests and per-master grant signals of the access switch
interface ahb_rr_switch_if #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0]   slave_done;
  logic [2*NUM_MASTERS-1:0] htrans;
  logic                     timeout_clr;
  logic [NUM_MASTERS-1:0]   hready;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic                     hold_timeout;

  modport master (
    output slave_done, htrans, timeout_clr,
    input  hready, grant_valid, grant_idx, hold_timeout
  );

  modport slave (
    input  slave_done, htrans, timeout_clr,
    output hready, grant_valid, grant_idx, hold_timeout
  );
endinterface

// File: rtl/ahb_rr_switch.sv
// rtl/ahb_rr_switch.sv - N-master AHB-Lite access switch, round-robin or fixed priority, hold watchdog
module ahb_rr_switch #(
  parameter  int NUM_MASTERS = 3,
  parameter  int RR_EN       = 1,
  parameter  int MAX_HOLD    = 64,
  parameter  int CNT_W       = 16,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_rr_switch_if.slave  bus
);
  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic [IDX_W-1:0]       last_idx, last_nxt;
  logic [CNT_W-1:0]       hold_cnt, hold_nxt;
  logic [NUM_MASTERS-1:0] pending, pending_nxt;
  logic [NUM_MASTERS-1:0] grant;
  logic                   timeout_q;
  logic                   timeout_set;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;

  // Done beats a same-cycle NONSEQ; the dropped NONSEQ must be reissued.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (bus.slave_done[i])
        pending_nxt[i] = 1'b0;
      else if (bus.htrans[2*i +: 2] == 2'b10)
        pending_nxt[i] = 1'b1;
    end
  end

  // The RR scan starts after the current owner, or after the last released owner when idle.
  always_comb begin
    int start;
    int cand;
    win_idx   = '0;
    win_found = |pending;
    start     = (state == S_OWNED) ? int'(owner) : int'(last_idx);
    cand      = 0;
    if (RR_EN != 0) begin
      for (int j = NUM_MASTERS; j >= 1; j--) begin
        cand = (start + j) % NUM_MASTERS;
        if (pending[cand])
          win_idx = IDX_W'(cand);
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (pending[i])
          win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_idx;
    hold_nxt  = hold_cnt;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt = S_OWNED;
          owner_nxt = win_idx;
          hold_nxt  = '0;
        end
      end
      S_OWNED: begin
        if (pending[owner]) begin
          if (hold_cnt != {CNT_W{1'b1}})
            hold_nxt = hold_cnt + CNT_W'(1);
        end else begin
          last_nxt = owner;
          hold_nxt = '0;
          if (win_found) begin
            owner_nxt = win_idx;
          end else begin
            state_nxt = S_IDLE;
            owner_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        owner_nxt = '0;
      end
    endcase
  end

  assign grant       = (state == S_OWNED) ? (NUM_MASTERS'(1) << owner) : '0;
  assign timeout_set = (state == S_OWNED) && (hold_cnt >= CNT_W'(MAX_HOLD - 1)) &&
                       (|(pending & ~grant));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      owner     <= '0;
      last_idx  <= IDX_W'(NUM_MASTERS - 1);
      hold_cnt  <= '0;
      pending   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last_idx <= last_nxt;
      hold_cnt <= hold_nxt;
      pending  <= pending_nxt;
      if (timeout_set)
        timeout_q <= 1'b1;
      else if (bus.timeout_clr)
        timeout_q <= 1'b0;
    end
  end

  assign bus.hready       = grant;
  assign bus.grant_valid  = (state == S_OWNED);
  assign bus.grant_idx    = (state == S_OWNED) ? owner : '0;
  assign bus.hold_timeout = timeout_q;
endmodule

// File: tb/tb_ahb_rr_switch.sv
// tb/tb_ahb_rr_switch.sv - checks three switch configurations against a per-cycle behavioural model
module tb_ahb_rr_switch;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*N-1:0] htrans = '0;
  logic [N-1:0]   done_man = '0;
  logic [N-1:0]   done_auto [3];
  logic           clr = 1'b0;
  logic           auto_en = 1'b0;

  ahb_rr_switch_if #(.NUM_MASTERS(N)) bus0 ();
  ahb_rr_switch_if #(.NUM_MASTERS(N)) bus1 ();
  ahb_rr_switch_if #(.NUM_MASTERS(N)) bus2 ();

  assign bus0.htrans = htrans;  assign bus0.slave_done = done_man | done_auto[0];  assign bus0.timeout_clr = clr;
  assign bus1.htrans = htrans;  assign bus1.slave_done = done_man | done_auto[1];  assign bus1.timeout_clr = clr;
  assign bus2.htrans = htrans;  assign bus2.slave_done = done_man | done_auto[2];  assign bus2.timeout_clr = clr;

  logic [N-1:0] h  [3];
  logic         gv [3];
  logic [1:0]   gi [3];
  logic         to [3];
  assign h[0] = bus0.hready; assign gv[0] = bus0.grant_valid; assign gi[0] = bus0.grant_idx; assign to[0] = bus0.hold_timeout;
  assign h[1] = bus1.hready; assign gv[1] = bus1.grant_valid; assign gi[1] = bus1.grant_idx; assign to[1] = bus1.hold_timeout;
  assign h[2] = bus2.hready; assign gv[2] = bus2.grant_valid; assign gi[2] = bus2.grant_idx; assign to[2] = bus2.hold_timeout;

  ahb_rr_switch #(.NUM_MASTERS(N), .RR_EN(1), .MAX_HOLD(64), .CNT_W(16)) dut_rr (.HCLK(clk), .HRESETn(rst_n), .bus(bus0));
  ahb_rr_switch #(.NUM_MASTERS(N), .RR_EN(0), .MAX_HOLD(64), .CNT_W(16)) dut_fp (.HCLK(clk), .HRESETn(rst_n), .bus(bus1));
  ahb_rr_switch #(.NUM_MASTERS(N), .RR_EN(1), .MAX_HOLD(4),  .CNT_W(16)) dut_wd (.HCLK(clk), .HRESETn(rst_n), .bus(bus2));

  int rr_cfg [3] = '{1, 0, 1};
  int mh_cfg [3] = '{64, 64, 4};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] one_hot_of(input int k);
    return (k < 0) ? '0 : (N'(1) << k);
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int winner(input int d, input int after, input logic [N-1:0] p);
    if (rr_cfg[d] != 0) begin
      for (int j = 1; j <= N; j++) if (p[(after + j) % N]) return (after + j) % N;
    end else begin
      for (int i = 0; i < N; i++) if (p[i]) return i;
    end
    return -1;
  endfunction

  // Model: owner is -1 when nobody holds the slave path.
  logic [N-1:0] m_pend [3] = '{default: '0};
  int           m_own  [3] = '{-1, -1, -1};
  int           m_last [3] = '{N-1, N-1, N-1};
  int           m_hold [3] = '{0, 0, 0};
  logic         m_to   [3] = '{default: 1'b0};
  logic [N-1:0] md_done, md_old;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_pend[d] = '0; m_own[d] = -1; m_last[d] = N - 1; m_hold[d] = 0; m_to[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        md_done = done_man | done_auto[d];
        md_old  = m_pend[d];
        for (int i = 0; i < N; i++) begin
          if (md_done[i]) m_pend[d][i] = 1'b0;
          else if (htrans[2*i +: 2] == 2'b10) m_pend[d][i] = 1'b1;
        end
        if (m_own[d] >= 0 && m_hold[d] >= mh_cfg[d] - 1 && (md_old & ~one_hot_of(m_own[d])) != '0)
          m_to[d] = 1'b1;
        else if (clr)
          m_to[d] = 1'b0;
        if (m_own[d] < 0) begin
          if (md_old != '0) begin
            m_own[d]  = winner(d, m_last[d], md_old);
            m_hold[d] = 0;
          end
        end else if (md_old[m_own[d]]) begin
          if (m_hold[d] < 65535) m_hold[d]++;
        end else begin
          m_last[d] = m_own[d];
          m_hold[d] = 0;
          m_own[d]  = (md_old != '0) ? winner(d, m_own[d], md_old) : -1;
        end
      end
    end
  end

  // Grant order per DUT, one hex digit per new owner (index+1).
  int           ord_code [3] = '{0, 0, 0};
  logic [N-1:0] c_prev   [3] = '{default: '0};

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d hready", d), 32'(h[d]), 32'(one_hot_of(m_own[d])));
      chk($sformatf("dut%0d grant_valid", d), 32'(gv[d]), 32'(m_own[d] >= 0));
      chk($sformatf("dut%0d grant_idx", d), 32'(gi[d]), (m_own[d] < 0) ? 32'd0 : 32'(m_own[d]));
      chk($sformatf("dut%0d hold_timeout", d), 32'(to[d]), 32'(m_to[d]));
      chk($sformatf("dut%0d onehot0", d), 32'($onehot0(h[d])), 32'd1);
      chk($sformatf("dut%0d valid_vs_hready", d), 32'(gv[d]), 32'(|h[d]));
      chk($sformatf("dut%0d idx_vs_hready", d), 32'(gi[d]), 32'(idx_of(h[d])));
      if (h[d] != '0 && h[d] != c_prev[d])
        ord_code[d] = ord_code[d] * 16 + idx_of(h[d]) + 1;
      c_prev[d] = h[d];
    end
  end

  // Slave responder: signals done two cycles after a master gains the grant.
  int           r_cnt  [3];
  logic [N-1:0] r_prev [3];
  initial begin
    for (int d = 0; d < 3; d++) begin done_auto[d] = '0; r_cnt[d] = 0; r_prev[d] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (!auto_en) begin
          r_cnt[d] = 0; r_prev[d] = h[d]; done_auto[d] = '0;
        end else begin
          if (h[d] != r_prev[d]) r_cnt[d] = 0; else r_cnt[d]++;
          r_prev[d]    = h[d];
          done_auto[d] = (r_cnt[d] == 2) ? h[d] : '0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; htrans = '0; done_man = '0; clr = 1'b0; auto_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) ord_code[d] = 0;
  endtask

  initial begin
    // single request, grant latency and release
    do_reset();
    for (int d = 0; d < 3; d++) chk($sformatf("reset dut%0d hready", d), 32'(h[d]), 32'd0);
    htrans = 6'b001000;
    step(1); htrans = '0;
    chk("t1 hready@1", 32'(h[0]), 32'd0);
    step(1);
    chk("t1 hready@2", 32'(h[0]), 32'b010);
    chk("t1 grant_idx@2", 32'(gi[0]), 32'd1);
    step(2); done_man = 3'b010;
    step(1); done_man = '0;
    chk("t1 hready@5", 32'(h[0]), 32'b010);
    step(1);
    chk("t1 hready@6", 32'(h[0]), 32'd0);
    chk("t1 grant_valid@6", 32'(gv[0]), 32'd0);

    // all three request together, m0 re-requests during the m2 grant
    do_reset();
    auto_en = 1'b1;
    htrans = 6'b101010;
    step(1); htrans = '0;
    step(9);
    chk("t2 rr owner m2", 32'(h[0]), 32'b100);
    htrans = 6'b000010;
    step(1); htrans = '0;
    step(10);
    chk("t2 rr order", 32'(ord_code[0]), 32'h1231);
    chk("t2 fp order", 32'(ord_code[1]), 32'h1231);
    chk("t2 wd order", 32'(ord_code[2]), 32'h1231);

    // m0 re-requests during the m1 grant
    do_reset();
    auto_en = 1'b1;
    htrans = 6'b101010;
    step(1); htrans = '0;
    step(5);
    chk("t3 owner m1", 32'(h[1]), 32'b010);
    htrans = 6'b000010;
    step(1); htrans = '0;
    step(14);
    chk("t3 rr order", 32'(ord_code[0]), 32'h1231);
    chk("t3 fp order", 32'(ord_code[1]), 32'h1213);

    // done and NONSEQ collide on m0
    do_reset();
    htrans = 6'b000010; done_man = 3'b001;
    step(1); done_man = '0;
    step(1); htrans = '0;
    chk("t4 dropped nonseq", 32'(h[0]), 32'd0);
    step(1);
    chk("t4 reissued grant", 32'(h[0]), 32'b001);
    done_man = 3'b001;
    step(1); done_man = '0;
    step(2);
    chk("t4 released", 32'(h[0]), 32'd0);

    // watchdog on the MAX_HOLD=4 instance, then asynchronous reset mid-grant
    do_reset();
    htrans = 6'b100010;
    step(1); htrans = '0;
    step(1);
    chk("t5 m0 owns", 32'(h[2]), 32'b001);
    step(3);
    chk("t5 timeout@5", 32'(to[2]), 32'd0);
    step(1);
    chk("t5 timeout@6", 32'(to[2]), 32'd1);
    clr = 1'b1;
    step(1); clr = 1'b0;
    chk("t5 set beats clr", 32'(to[2]), 32'd1);
    done_man = 3'b100;
    step(1); done_man = '0; clr = 1'b1;
    step(1); clr = 1'b0;
    chk("t5 cleared", 32'(to[2]), 32'd0);
    htrans = 6'b100000;
    step(1); htrans = '0;
    chk("t5 still clear", 32'(to[2]), 32'd0);
    step(1);
    chk("t5 re-set", 32'(to[2]), 32'd1);
    chk("t5 long hold no timeout", 32'(to[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("t5 async reset dut%0d hready", d), 32'(h[d]), 32'd0);
    chk("t5 async reset timeout", 32'(to[2]), 32'd0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
